// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches over a multi-cycle req/ack
// handshake with timeout, and applies the controller's PC update commands.
module fetch_unit #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   TIMEOUT  = 15,
  parameter logic [DW-1:0] HLT_WORD = DW'(32'hF000_0000)
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          ir_load,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          pc_rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] instr,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [AW-1:0] pc,
  output logic          fetch_busy,
  output logic          fetch_err
);

  // Counter holds the number of no-ack WAIT edges seen so far (0..TIMEOUT-1).
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Fetch handshake FSM; IR and error flag only change on fetch completion.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      imem_addr  <= '0;
      imem_req   <= 1'b0;
      fetch_busy <= 1'b0;
      instr      <= '0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ir_load) begin
            state      <= WAIT;
            imem_addr  <= pc;
            wait_cnt   <= '0;
            imem_req   <= 1'b1;
            fetch_busy <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state      <= IDLE;
            instr      <= imem_rdata;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state      <= IDLE;
            instr      <= HLT_WORD;
            fetch_err  <= 1'b1;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

  // PC update runs regardless of fetch state; pc_rst has priority.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc <= '0;
    end else if (pc_rst) begin
      pc <= '0;
    end else if (pc_write) begin
      if (!pc_sel)
        pc <= pc + AW'(1);
      else if (br_sel)
        pc <= instr[AW-1:0];
      else
        pc <= pc + instr[AW-1:0];
    end
  end

  assign opcode = instr[31:28];
  assign mm     = instr[27:24];

endmodule
